// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate checker: FSM encoding, gate response bit
// positions and the number of stimulus vectors in one run.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam int GATE_W = 6;

    localparam int AND_B  = 0;
    localparam int OR_B   = 1;
    localparam int NOT_B  = 2;
    localparam int XOR_B  = 3;
    localparam int NAND_B = 4;
    localparam int NOR_B  = 5;

    localparam int NUM_VECTORS = 4;

    localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);
    localparam logic [2:0] MAX_ERR  = 3'(NUM_VECTORS);

endpackage : gate_chk_pkg

// File: rtl/gate_ref.sv
// Golden combinational model of the six basic gates for one {a,b} input pair.
module gate_ref
    import gate_chk_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [GATE_W-1:0] exp
);

    always_comb begin
        // NOTE: a default assignment before the individual bits keeps every
        // path fully assigned, so no latch can ever be inferred here.
        exp         = '0;
        exp[AND_B]  = a & b;
        exp[OR_B]   = a | b;
        exp[NOT_B]  = ~a;
        exp[XOR_B]  = a ^ b;
        exp[NAND_B] = ~(a & b);
        exp[NOR_B]  = ~(a | b);
    end

endmodule : gate_ref

// File: rtl/gate_checker.sv
// Drives the four {a,b} vectors into an external gate block, waits for it to
// settle, and accumulates per-vector mismatches against the golden model.
module gate_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_in,
    output logic              a,
    output logic              b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2:0]        err_count,
    output logic [GATE_W-1:0] fail_mask
);

    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [1:0]        idx;
    logic [1:0]        idx_next;
    logic [7:0]        cnt;
    logic [GATE_W-1:0] exp_vec;
    logic [GATE_W-1:0] mismatch;

    gate_ref u_gate_ref (
        .a   (a),
        .b   (b),
        .exp (exp_vec)
    );

    assign idx_next = idx + 2'd1;
    assign mismatch = gate_in ^ exp_vec;
    assign pass     = done & (err_count == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here update
            // from pre-edge values, so the order of statements does not matter.
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        {a, b}    <= 2'b00;
                        cnt       <= '0;
                        err_count <= '0;
                        fail_mask <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end

                SETTLE: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == LAST_CNT) begin
                        state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    // A vector counts once however many gate bits disagree.
                    if (|mismatch) begin
                        if (err_count != MAX_ERR) begin
                            err_count <= err_count + 3'd1;
                        end
                        fail_mask <= fail_mask | mismatch;
                    end
                    if (idx != LAST_IDX) begin
                        idx    <= idx_next;
                        {a, b} <= idx_next;
                        cnt    <= '0;
                        state  <= SETTLE;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : gate_checker

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker: a behavioural gate block with
// selectable faults, and a scoreboard of expected end-of-run results.
module tb_gate_checker;

    localparam int SETTLE = 4;
    localparam int RUN_EDGES = 4 * (SETTLE + 1);

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] gate_in;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [5:0] fail_mask;

    // 0: fault-free, 1: and stuck at 0, 2: xor inverted, 3: nor stuck at 1
    int fault_mode;

    typedef struct {
        logic [2:0] err;
        logic [5:0] mask;
        logic       pass;
    } exp_t;

    exp_t sb_q[$];

    int tests_run;
    int tests_failed;

    gate_checker #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .gate_in   (gate_in),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_mask (fail_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        gate_in[0] = a & b;
        gate_in[1] = a | b;
        gate_in[2] = ~a;
        gate_in[3] = a ^ b;
        gate_in[4] = ~(a & b);
        gate_in[5] = ~(a | b);
        case (fault_mode)
            1:       gate_in[0] = 1'b0;
            2:       gate_in[3] = ~(a ^ b);
            3:       gate_in[5] = 1'b1;
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts a start on the next edge and follows the run to its done edge.
    task automatic do_run(input int fault, input logic [2:0] e_err,
                          input logic [5:0] e_mask, input int repulse_k,
                          input bit hold_start, input string name);
        exp_t e;
        exp_t got;
        logic [1:0] exp_ab;
        fault_mode = fault;
        e.err  = e_err;
        e.mask = e_mask;
        e.pass = (e_err == 3'd0);
        sb_q.push_back(e);
        start = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        for (int k = 0; k < RUN_EDGES; k++) begin
            exp_ab = 2'(k / (SETTLE + 1));
            tests_run++;
            if ({a, b} !== exp_ab || busy !== 1'b1 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s edge%0d ab/busy/done: got %b/%b/%b want %b/1/0",
                         name, k, {a, b}, busy, done, exp_ab);
            end
            if (k == 0) begin
                tests_run++;
                if (err_count !== 3'd0 || fail_mask !== 6'd0 || pass !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s start_clear: err=%0d mask=%b pass=%b want 0/000000/0",
                             name, err_count, fail_mask, pass);
                end
            end
            if (k == repulse_k - 1) start = 1'b1;
            if (k == repulse_k) start = 1'b0;
            step();
        end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || {a, b} !== 2'b11) begin
            tests_failed++;
            $display("FAIL %s done_edge: done=%b busy=%b ab=%b want 1/0/11",
                     name, done, busy, {a, b});
        end
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s scoreboard: queue empty at done, want 1 entry", name);
        end else begin
            got.err  = err_count;
            got.mask = fail_mask;
            got.pass = pass;
            e = sb_q.pop_front();
            if (got.err !== e.err || got.mask !== e.mask || got.pass !== e.pass) begin
                tests_failed++;
                $display("FAIL %s result: err=%0d mask=%b pass=%b want err=%0d mask=%b pass=%b",
                         name, got.err, got.mask, got.pass, e.err, e.mask, e.pass);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        fault_mode = 0;
        #12;
        tests_run++;
        if ({a, b, busy, done, pass, err_count, fail_mask} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_active: outputs=%b want all 0",
                     {a, b, busy, done, pass, err_count, fail_mask});
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            tests_run++;
            if ({a, b, busy, done, pass, err_count, fail_mask} !== 14'd0) begin
                tests_failed++;
                $display("FAIL idle_quiet cycle%0d: outputs=%b want all 0",
                         i, {a, b, busy, done, pass, err_count, fail_mask});
            end
        end
    endtask

    task automatic test_clean_run();
        do_run(0, 3'd0, 6'b000000, -1, 1'b0, "clean");
    endtask

    task automatic test_faults();
        do_run(1, 3'd1, 6'b000001, -1, 1'b0, "and_stuck0");
        do_run(2, 3'd4, 6'b001000, -1, 1'b0, "xor_inv");
        do_run(3, 3'd3, 6'b100000, -1, 1'b0, "nor_stuck1");
    endtask

    task automatic test_reset_mid_run();
        fault_mode = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({a, b, busy, done, pass, err_count, fail_mask} !== 14'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: outputs=%b want all 0",
                     {a, b, busy, done, pass, err_count, fail_mask});
        end
        step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if ({busy, done, err_count, fail_mask} !== 11'd0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: outputs=%b want all 0",
                     {busy, done, err_count, fail_mask});
        end
        do_run(0, 3'd0, 6'b000000, -1, 1'b0, "after_reset");
    endtask

    task automatic test_start_ignored();
        do_run(0, 3'd0, 6'b000000, 3, 1'b0, "repulse");
    endtask

    task automatic test_done_restart();
        do_run(1, 3'd1, 6'b000001, -1, 1'b0, "pre_restart");
        step();
        tests_run++;
        if (done !== 1'b1 || err_count !== 3'd1) begin
            tests_failed++;
            $display("FAIL done_hold: done=%b err=%0d want 1/1", done, err_count);
        end
        do_run(0, 3'd0, 6'b000000, -1, 1'b0, "restart");
    endtask

    task automatic test_back_to_back();
        do_run(2, 3'd4, 6'b001000, -1, 1'b1, "b2b_first");
        do_run(0, 3'd0, 6'b000000, -1, 1'b0, "b2b_second");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_clean_run();
        test_faults();
        test_reset_mid_run();
        test_start_ignored();
        test_done_restart();
        test_back_to_back();
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_gate_checker

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles each stimulus vector is held before sampling; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level-sampled run request.
REQ-005 a  output  1  stimulus to DUT input a (registered).
REQ-006 b  output  1  stimulus to DUT input b (registered).
REQ-007 gate_in  input  6  DUT responses: [0]=and, [1]=or, [2]=not (NOT a), [3]=xor, [4]=nand, [5]=nor.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high from run completion until the next accepted start or reset.
REQ-010 pass  output  1  equals done AND (err_count == 0).
REQ-011 err_count  output  3  number of vectors (0..4) with at least one mismatching gate bit.
REQ-012 fail_mask  output  6  sticky OR of mismatching gate_in bit positions across the run.

Function
REQ-013 The FSM shall have exactly three states: IDLE, SETTLE, SAMPLE; DONE is IDLE with done=1.
REQ-014 In IDLE, start=1 on a rising edge shall load: idx=0, {a,b}=2'b00, cnt=0, err_count=0, fail_mask=0, done=0, busy=1, next state SETTLE.
REQ-015 {a,b} shall always equal {idx[1],idx[0]}, giving the vector order 00, 01, 10, 11.
REQ-016 SETTLE: cnt (8 bits) shall increment each cycle; when cnt == SETTLE_CYCLES-1 the next state shall be SAMPLE.
REQ-017 SAMPLE: the block shall compare gate_in against the expected vector {~(a|b), ~(a&b), a^b, ~a, a|b, a&b} (bit 5 down to 0).
REQ-018 SAMPLE, any mismatch: err_count shall increment by 1; fail_mask |= mismatch bits, in the same cycle.
REQ-019 SAMPLE with idx<3: idx+1, cnt=0, next state SETTLE.
REQ-020 SAMPLE with idx==3: busy=0, done=1, {a,b} held at 11, next state IDLE.
REQ-021 Each vector shall occupy SETTLE_CYCLES+1 cycles; done shall rise 4*(SETTLE_CYCLES+1) clock edges after the edge that accepted start.
REQ-022 start while busy=1 shall be ignored.
REQ-023 start=1 while done=1 shall restart per REQ-014, clearing done, err_count and fail_mask on that edge.
REQ-024 start held high continuously shall cause back-to-back runs, with one IDLE cycle between runs.
REQ-025 err_count shall not wrap; 4 is the maximum value reachable.

Reset
REQ-026 rst_n low shall asynchronously force: state=IDLE, idx=0, cnt=0, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0.
REQ-027 Reset asserted mid-run shall abandon the run with no partial results retained.
REQ-028 Reset release shall be followed by IDLE; the first start is accepted no earlier than the first edge after release.

Structure
REQ-029 A shared package gate_chk_pkg shall hold the state encoding, the gate bit index constants (AND_B..NOR_B) and the vector count (4).
REQ-030 The expected-value function shall be a combinational sub-module gate_ref (inputs a, b; output exp[5:0]), reusable by other benches.
REQ-031 All outputs shall be driven directly from registers, except pass, which is a single AND of registered signals.

Verification
REQ-032 Reset -> all outputs 0; state IDLE; start low keeps all outputs 0 for 50 cycles.
REQ-033 Fault-free gates DUT, SETTLE_CYCLES=4, 1-cycle start pulse -> {a,b} = 00,01,10,11, each held 5 cycles; done at edge 20; pass=1, err_count=0, fail_mask=0.
REQ-034 and bit stuck at 0 -> only vector 11 fails; err_count=1, fail_mask=6'b000001, pass=0.
REQ-035 xor bit inverted -> all four vectors fail; err_count=4, fail_mask=6'b001000.
REQ-036 rst_n pulsed low at cycle 7 of a run -> immediate a=b=0, busy=0, done=0; a new start then completes with pass=1.
REQ-037 start re-pulsed at cycle 3 of a run -> ignored, so done still arrives at edge 20; start in done state -> done=0, err_count=0 on the next edge, and a fresh run follows.
